// File: rtl/chacha20_xor_stream.sv
// chacha20_xor_stream: keystream consumer for the chacha20 block core.
// Requests keystream blocks, XORs them into a 32-bit valid/ready stream and
// owns the 64-bit block counter.
// Optional feature macro: CHACHA20_XOR_PREFETCH_EN (double-buffered keystream).
module chacha20_xor_stream (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [255:0] key,
   input  logic [63:0]  nonce,
   input  logic [63:0]  counter_init,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_last,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [31:0]  m_data,
   output logic         m_last,
   output logic         core_start,
   output logic [255:0] core_key,
   output logic [63:0]  core_nonce,
   output logic [63:0]  core_index,
   input  logic         core_done,
   input  logic [511:0] core_out,
   output logic         busy,
   output logic         ctr_wrap
);

   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RUN, ST_FLUSH} state_e;

   // core expects the block counter little-endian byte order
   function automatic logic [63:0] bswap64(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = v[56-8*i +: 8];
      return r;
   endfunction

   state_e             state_q, state_d;
   logic [255:0]       key_q, key_d;
   logic [63:0]        nonce_q, nonce_d;
   logic [63:0]        ctr_q, ctr_d;
   logic [15:0][31:0]  buf_q, buf_d;      // buf_q[15] is keystream word 0
   logic [3:0]         ptr_q, ptr_d;
   logic               m_valid_q, m_valid_d;
   logic [31:0]        m_data_q, m_data_d;
   logic               m_last_q, m_last_d;
   logic               ctr_wrap_q, ctr_wrap_d;
   logic [255:0]       core_key_q, core_key_d;
   logic [63:0]        core_nonce_q, core_nonce_d;
   logic [63:0]        core_index_q, core_index_d;
   logic               in_xfer;
   logic [31:0]        ks_word;
   logic [63:0]        ctr_inc;

`ifdef CHACHA20_XOR_PREFETCH_EN
   logic [15:0][31:0]  spare_q, spare_d;
   logic               spare_vld_q, spare_vld_d;
   logic               pf_pend_q, pf_pend_d;    // prefetch request in flight
   logic               pf_start_q, pf_start_d;
   logic               pf_arrive;

   assign pf_arrive  = pf_pend_q && core_done;
   assign core_start = (state_q == ST_REQ) || pf_start_q;
`else
   assign core_start = (state_q == ST_REQ);
`endif

   // load always wins over an input word in the same cycle
   assign s_ready    = (state_q == ST_RUN) && (!m_valid_q || m_ready) && !load;
   assign in_xfer    = s_valid && s_ready;
   assign ks_word    = buf_q[4'd15 - ptr_q];
   assign ctr_inc    = ctr_q + 64'd1;
   assign busy       = (state_q != ST_IDLE);
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_last     = m_last_q;
   assign ctr_wrap   = ctr_wrap_q;
   assign core_key   = core_key_q;
   assign core_nonce = core_nonce_q;
   assign core_index = core_index_q;

   // next-state, counter and keystream buffer control
   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      nonce_d      = nonce_q;
      ctr_d        = ctr_q;
      buf_d        = buf_q;
      ptr_d        = ptr_q;
      ctr_wrap_d   = ctr_wrap_q;
      core_key_d   = core_key_q;
      core_nonce_d = core_nonce_q;
      core_index_d = core_index_q;
`ifdef CHACHA20_XOR_PREFETCH_EN
      spare_d      = spare_q;
      spare_vld_d  = spare_vld_q;
      pf_pend_d    = pf_pend_q;
      pf_start_d   = 1'b0;
      // an arriving prefetch is either used below or dropped
      if (pf_arrive) pf_pend_d = 1'b0;
`endif

      if (load) begin
         key_d   = key;
         nonce_d = nonce;
         ctr_d   = counter_init;
         ptr_d   = '0;
         buf_d   = '0;
`ifdef CHACHA20_XOR_PREFETCH_EN
         spare_vld_d = 1'b0;
`endif
      end

      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_REQ;
`ifdef CHACHA20_XOR_PREFETCH_EN
               // a prefetch abandoned by s_last may still be in the core
               if (pf_pend_q && !core_done) state_d = ST_FLUSH;
`endif
            end
         end
         ST_REQ: begin
            if (!load) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (load) begin
               state_d = ST_FLUSH;
            end else if (core_done) begin
               buf_d   = core_out;
               ptr_d   = '0;
               state_d = ST_RUN;
`ifdef CHACHA20_XOR_PREFETCH_EN
               pf_start_d = 1'b1;
               pf_pend_d  = 1'b1;
`endif
            end
         end
         ST_RUN: begin
            if (load) begin
               state_d = ST_REQ;
`ifdef CHACHA20_XOR_PREFETCH_EN
               if (pf_pend_q && !core_done) state_d = ST_FLUSH;
`endif
            end else begin
`ifdef CHACHA20_XOR_PREFETCH_EN
               if (pf_arrive) begin
                  spare_d     = core_out;
                  spare_vld_d = 1'b1;
               end
`endif
               if (in_xfer) begin
                  ptr_d = ptr_q + 4'd1;
                  if (s_last) begin
                     state_d = ST_IDLE;
                  end else if (ptr_q == 4'd15) begin
                     ctr_d = ctr_inc;
                     if (ctr_inc == 64'd0) ctr_wrap_d = 1'b1;
`ifdef CHACHA20_XOR_PREFETCH_EN
                     if (spare_vld_q || pf_arrive) begin
                        buf_d       = spare_vld_q ? spare_q : core_out;
                        spare_vld_d = 1'b0;
                        pf_start_d  = 1'b1;
                        pf_pend_d   = 1'b1;
                     end else if (pf_pend_q) begin
                        // the in-flight prefetch is exactly the next block
                        state_d = ST_WAIT;
                     end else begin
                        state_d = ST_REQ;
                     end
`else
                     state_d = ST_REQ;
`endif
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (!load && core_done) state_d = ST_REQ;
         end
         default: state_d = ST_IDLE;
      endcase

      // request fields only change when a new request is about to go out
      if (state_d == ST_REQ) begin
         core_key_d   = key_d;
         core_nonce_d = nonce_d;
         core_index_d = bswap64(ctr_d);
      end
`ifdef CHACHA20_XOR_PREFETCH_EN
      else if (pf_start_d) begin
         core_key_d   = key_q;
         core_nonce_d = nonce_q;
         core_index_d = bswap64(ctr_d + 64'd1);
      end
`endif
   end

   // registered output word: XOR on input transfer, hold while stalled
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      if (load) begin
         m_valid_d = 1'b0;
      end else if (in_xfer) begin
         m_data_d  = s_data ^ ks_word;
         m_last_d  = s_last;
         m_valid_d = 1'b1;
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         key_q        <= '0;
         nonce_q      <= '0;
         ctr_q        <= '0;
         buf_q        <= '0;
         ptr_q        <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_last_q     <= 1'b0;
         ctr_wrap_q   <= 1'b0;
         core_key_q   <= '0;
         core_nonce_q <= '0;
         core_index_q <= '0;
`ifdef CHACHA20_XOR_PREFETCH_EN
         spare_q      <= '0;
         spare_vld_q  <= 1'b0;
         pf_pend_q    <= 1'b0;
         pf_start_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         nonce_q      <= nonce_d;
         ctr_q        <= ctr_d;
         buf_q        <= buf_d;
         ptr_q        <= ptr_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_last_q     <= m_last_d;
         ctr_wrap_q   <= ctr_wrap_d;
         core_key_q   <= core_key_d;
         core_nonce_q <= core_nonce_d;
         core_index_q <= core_index_d;
`ifdef CHACHA20_XOR_PREFETCH_EN
         spare_q      <= spare_d;
         spare_vld_q  <= spare_vld_d;
         pf_pend_q    <= pf_pend_d;
         pf_start_q   <= pf_start_d;
`endif
      end
   end

endmodule

// File: tb/tb_chacha20_xor_stream.sv
// Bench for chacha20_xor_stream with a behavioural stand-in for the core.
module tb_chacha20_xor_stream;

   localparam logic [255:0] RFC_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [63:0]  RFC_NONCE = 64'h0000004a00000000;
   localparam logic [255:0] KEY_B     = 256'hdeadbeef_01234567_89abcdef_cafef00d_0badc0de_11223344_55667788_99aabbcc;
   localparam logic [255:0] KEY_C     = 256'h5555aaaa_12121212_34343434_56565656_78787878_9a9a9a9a_bcbcbcbc_dededede;
   localparam int           LAT       = 5;

   logic         clock = 1'b0;
   logic         reset, load, s_valid, s_last, m_ready;
   logic [255:0] key;
   logic [63:0]  nonce, counter_init;
   logic [31:0]  s_data;
   logic         s_ready, m_valid, m_last, core_start, busy, ctr_wrap;
   logic [31:0]  m_data;
   logic [255:0] core_key;
   logic [63:0]  core_nonce, core_index;
   logic         core_done, mdl_done, inj_done;
   logic [511:0] core_out, mdl_out;

   int           n_chk = 0;
   int           n_bad = 0;
   logic [255:0] t_key;
   logic [63:0]  t_nonce, t_ctr0;
   logic [32:0]  exp_q[$];
   int           gaps;
   int           s0;

   // core model state
   int           lat_cnt = 0;
   int           n_start = 0;
   logic [63:0]  idx_log[64];
   logic [255:0] key_log[64];
   logic [255:0] mk;
   logic [63:0]  mn, mi;

   always #5 clock = ~clock;

   assign core_done = mdl_done | inj_done;
   assign core_out  = inj_done ? {16{32'h0f0f0f0f}} : mdl_out;

   chacha20_xor_stream dut (
      .clock(clock), .reset(reset), .load(load), .key(key), .nonce(nonce),
      .counter_init(counter_init), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .core_start(core_start),
      .core_key(core_key), .core_nonce(core_nonce), .core_index(core_index),
      .core_done(core_done), .core_out(core_out), .busy(busy), .ctr_wrap(ctr_wrap)
   );

   function automatic logic [63:0] bswap(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = v[56-8*i +: 8];
      return r;
   endfunction

   // stand-in keystream; word 0 of the RFC 7539 2.4.2 block is the real value
   function automatic logic [31:0] ks_word(input logic [255:0] k, input logic [63:0] n,
                                           input logic [63:0] idx, input int w);
      logic [31:0] wm;
      wm = 32'(w) + 32'd1;
      if (k == RFC_KEY && n == RFC_NONCE && idx == 64'h0100000000000000 && w == 0)
         return 32'h224f51f3;
      return k[31:0] ^ k[255:224] ^ n[31:0] ^ {n[47:32], n[63:48]} ^ idx[31:0] ^
             {idx[39:32], idx[63:40]} ^ (wm * 32'h9e3779b9);
   endfunction

   function automatic logic [511:0] ks_block(input logic [255:0] k, input logic [63:0] n,
                                             input logic [63:0] idx);
      logic [511:0] b;
      for (int w = 0; w < 16; w++) b[511-32*w -: 32] = ks_word(k, n, idx, w);
      return b;
   endfunction

   // core model: fixed latency, restarts on every start pulse
   always @(posedge clock) begin
      mdl_done <= 1'b0;
      if (core_start) begin
         lat_cnt          <= LAT;
         mk               <= core_key;
         mn               <= core_nonce;
         mi               <= core_index;
         idx_log[n_start] <= core_index;
         key_log[n_start] <= core_key;
         n_start          <= n_start + 1;
      end else if (lat_cnt != 0) begin
         lat_cnt <= lat_cnt - 1;
         if (lat_cnt == 1) begin
            mdl_done <= 1'b1;
            mdl_out  <= ks_block(mk, mn, mi);
         end
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c);
      @(negedge clock);
      key = k; nonce = n; counter_init = c; load = 1'b1;
      t_key = k; t_nonce = n; t_ctr0 = c;
      @(negedge clock);
      load = 1'b0;
      #1;
   endtask

   // push n words through, scoreboard every output word, count s_ready gaps
   task automatic stream(input int n, input logic [31:0] base, input bit rnd, output int ngap);
      int sent, got, cyc;
      logic acc, prev_stall, prev_rdy;
      logic [31:0] prev_data, ew;
      logic [32:0] e;
      sent = 0; got = 0; cyc = 0; acc = 1'b0; prev_stall = 1'b0; prev_rdy = 1'b0;
      prev_data = '0; ngap = 0;
      exp_q.delete();
      while (got < n && cyc < 3000) begin
         @(negedge clock);
         cyc++;
         if (acc) sent++;
         if (prev_stall) begin
            chk("stall_hold", 256'(m_data), 256'(prev_data));
            chk("stall_vld", 256'(m_valid), 256'(1));
         end
         m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         s_valid = (sent < n);
         s_data  = base + 32'(sent) * 32'h10203041;
         s_last  = (sent == n - 1);
         #1;
         if (s_valid && !s_ready && prev_rdy) ngap++;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 256'(1), 256'(0));
            else begin
               e = exp_q.pop_front();
               chk("m_data", 256'(m_data), 256'(e[31:0]));
               chk("m_last", 256'(m_last), 256'(e[32]));
            end
            got++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         acc        = s_valid && s_ready;
         if (acc) begin
            ew = ks_word(t_key, t_nonce, bswap(t_ctr0 + 64'(sent / 16)), sent % 16);
            exp_q.push_back({s_last, s_data ^ ew});
         end
         prev_rdy = s_ready;
      end
      s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      if (got < n) chk("stream_timeout", 256'(got), 256'(n));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; load = 1'b0; key = '0; nonce = '0; counter_init = '0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1; inj_done = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_s_ready", 256'(s_ready), 256'(0));
      chk("rst_m_valid", 256'(m_valid), 256'(0));
      chk("rst_core_start", 256'(core_start), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_ctr_wrap", 256'(ctr_wrap), 256'(0));
      chk("rst_core_index", 256'(core_index), 256'(0));
      reset = 1'b0;

      // RFC 7539 encryption example, first word
      s0 = n_start;
      do_load(RFC_KEY, RFC_NONCE, 64'd1);
      chk("t1_core_start", 256'(core_start), 256'(1));
      chk("t1_core_index", 256'(core_index), 256'(64'h0100000000000000));
      chk("t1_core_key", core_key, RFC_KEY);
      chk("t1_core_nonce", 256'(core_nonce), 256'(RFC_NONCE));
      stream(1, 32'h4c616469, 1'b0, gaps);
      chk("t1_m_data", 256'(m_data), 256'(32'h6e2e359a));
      chk("t1_idle", 256'(busy), 256'(0));

      // 40 words across three blocks
      s0 = n_start;
      do_load(KEY_B, 64'h0102030405060708, 64'd1);
      stream(40, 32'h11111111, 1'b0, gaps);
      chk("t2_starts", 256'(n_start - s0), 256'(3));
      chk("t2_idx1", 256'(idx_log[s0]), 256'(64'h0100000000000000));
      chk("t2_idx2", 256'(idx_log[s0+1]), 256'(64'h0200000000000000));
      chk("t2_idx3", 256'(idx_log[s0+2]), 256'(64'h0300000000000000));
      chk("t2_gaps", 256'(gaps), 256'(2));

      // random output back-pressure
      do_load(KEY_C, 64'h00000000cafebabe, 64'd5);
      stream(37, 32'h0badf00d, 1'b1, gaps);
      chk("t3_wrap_clear", 256'(ctr_wrap), 256'(0));

      // reload while a request is in flight
      s0 = n_start;
      do_load(KEY_B, 64'h1111111111111111, 64'd9);
      do_load(KEY_C, 64'h2222222222222222, 64'd7);
      chk("t4_flush_busy", 256'(busy), 256'(1));
      chk("t4_flush_nostart", 256'(core_start), 256'(0));
      stream(2, 32'h77777777, 1'b0, gaps);
      chk("t4_starts", 256'(n_start - s0), 256'(2));
      chk("t4_key", key_log[s0+1], KEY_C);
      chk("t4_idx", 256'(idx_log[s0+1]), 256'(64'h0700000000000000));

      // counter wrap
      s0 = n_start;
      do_load(KEY_B, 64'h0, 64'hFFFFFFFFFFFFFFFF);
      stream(17, 32'h01020304, 1'b0, gaps);
      chk("t5_starts", 256'(n_start - s0), 256'(2));
      chk("t5_idx1", 256'(idx_log[s0]), 256'(64'hFFFFFFFFFFFFFFFF));
      chk("t5_idx2", 256'(idx_log[s0+1]), 256'(0));
      chk("t5_wrap", 256'(ctr_wrap), 256'(1));

      // reset in RUN with an output word pending
      do_load(KEY_C, 64'h3333333333333333, 64'd2);
      for (int i = 0; i < 50 && !s_ready; i++) begin
         @(negedge clock);
         #1;
      end
      chk("t6_run", 256'(s_ready), 256'(1));
      s_valid = 1'b1; s_data = 32'h89abcdef; s_last = 1'b0; m_ready = 1'b0;
      @(negedge clock);
      s_valid = 1'b0;
      #1;
      chk("t6_m_valid", 256'(m_valid), 256'(1));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("t6_m_valid0", 256'(m_valid), 256'(0));
      chk("t6_m_data0", 256'(m_data), 256'(0));
      chk("t6_m_last0", 256'(m_last), 256'(0));
      chk("t6_busy0", 256'(busy), 256'(0));
      chk("t6_s_ready0", 256'(s_ready), 256'(0));
      chk("t6_wrap0", 256'(ctr_wrap), 256'(0));
      chk("t6_core_key0", core_key, 256'(0));
      chk("t6_core_index0", 256'(core_index), 256'(0));
      inj_done = 1'b1;
      @(negedge clock);
      inj_done = 1'b0;
      #1;
      chk("t6_done_busy", 256'(busy), 256'(0));
      chk("t6_done_start", 256'(core_start), 256'(0));
      chk("t6_done_vld", 256'(m_valid), 256'(0));
      @(negedge clock);
      #1;
      chk("t6_done_busy2", 256'(busy), 256'(0));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
